// File: rtl/alu_cmd_master_if.sv
// Handshake bundle between the ALU command master and its UART FIFO pair / host.
// master: the command initiator; slave: the host and FIFO environment driving it.
interface alu_cmd_master_if #(
    parameter int BUS_SIZE = 8,
    parameter int OP_SIZE  = 6
);
    logic                i_start;
    logic [BUS_SIZE-1:0] i_op_a;
    logic [BUS_SIZE-1:0] i_op_b;
    logic [OP_SIZE-1:0]  i_op_code;
    logic                tx_full;
    logic                rx_empty;
    logic [BUS_SIZE-1:0] i_rx_data;
    logic [BUS_SIZE-1:0] o_tx_data;
    logic                o_wr;
    logic                o_rd;
    logic [BUS_SIZE-1:0] o_result;
    logic                o_done;
    logic                o_timeout;
    logic                o_busy;

    modport master (
        input  i_start, i_op_a, i_op_b, i_op_code, tx_full, rx_empty, i_rx_data,
        output o_tx_data, o_wr, o_rd, o_result, o_done, o_timeout, o_busy
    );

    modport slave (
        output i_start, i_op_a, i_op_b, i_op_code, tx_full, rx_empty, i_rx_data,
        input  o_tx_data, o_wr, o_rd, o_result, o_done, o_timeout, o_busy
    );
endinterface

// File: rtl/alu_cmd_master.sv
// Host-side ALU command initiator: pushes A, B, opcode into the UART TX FIFO,
// then waits (bounded) for one result byte from the RX FIFO.
module alu_cmd_master #(
    parameter int BUS_SIZE       = 8,
    parameter int OP_SIZE        = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic              clk,
    input  logic              i_reset,
    alu_cmd_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_OP,
        WAIT_RES
    } state_t;

    state_t              state_q, state_d;
    logic [BUS_SIZE-1:0] op_a_q;
    logic [BUS_SIZE-1:0] op_b_q;
    logic [OP_SIZE-1:0]  op_code_q;
    logic [BUS_SIZE-1:0] result_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic                done_q;
    logic                timeout_q;

    logic                latch;
    logic                capture;
    logic                to_fire;
    logic                wr;
    logic                rd;
    logic [BUS_SIZE-1:0] tx_data;

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        capture = 1'b0;
        to_fire = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        tx_data = '0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    latch   = 1'b1;
                    state_d = SEND_A;
                end
            end
            SEND_A: begin
                tx_data = op_a_q;
                if (!bus.tx_full) begin
                    wr      = 1'b1;
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                tx_data = op_b_q;
                if (!bus.tx_full) begin
                    wr      = 1'b1;
                    state_d = SEND_OP;
                end
            end
            SEND_OP: begin
                tx_data = BUS_SIZE'(op_code_q);
                if (!bus.tx_full) begin
                    wr      = 1'b1;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                // Arriving data takes priority over a timeout on the same cycle.
                if (!bus.rx_empty) begin
                    rd      = 1'b1;
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    to_fire = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            result_q  <= '0;
            to_cnt_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= capture;
            if (latch) begin
                op_a_q    <= bus.i_op_a;
                op_b_q    <= bus.i_op_b;
                op_code_q <= bus.i_op_code;
            end
            if (capture) begin
                result_q <= bus.i_rx_data;
            end
            if (latch) begin
                timeout_q <= 1'b0;
            end else if (to_fire) begin
                timeout_q <= 1'b1;
            end
            // Counter runs only while staying in WAIT_RES, so it is 0 on every entry.
            if (state_q == WAIT_RES && state_d == WAIT_RES) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign bus.o_tx_data = tx_data;
    assign bus.o_wr      = wr;
    assign bus.o_rd      = rd;
    assign bus.o_result  = result_q;
    assign bus.o_done    = done_q;
    assign bus.o_timeout = timeout_q;
    assign bus.o_busy    = (state_q != IDLE);

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Host-side command initiator for the UART ALU link; it is the counterpart to the board-side command interface.
- On a start request it writes three bytes into the UART TX FIFO in this order: operand A, operand B, opcode.
- It then waits for one result byte from the UART RX FIFO.
- It drives a FIFO-based UART pair and is used for loopback self-test and for the host-emulation bench.

Parameters:
- BUS_SIZE, 8, width of data bytes, operands and result.
- OP_SIZE, 6, opcode width; must be at most BUS_SIZE.
- TIMEOUT_CYCLES, 1000000, clk cycles to wait for the result before aborting; must be at least 1.
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1, system clock.
- i_reset, input, 1, asynchronous active-high reset.
- i_start, input, 1, command request; sampled only in IDLE.
- i_op_a, input, BUS_SIZE, operand A.
- i_op_b, input, BUS_SIZE, operand B.
- i_op_code, input, OP_SIZE, ALU opcode.
- tx_full, input, 1, TX FIFO full.
- rx_empty, input, 1, RX FIFO empty.
- i_rx_data, input, BUS_SIZE, RX FIFO head word; first-word-fall-through, valid whenever rx_empty=0.
- o_tx_data, output, BUS_SIZE, byte presented to the TX FIFO.
- o_wr, output, 1, TX FIFO write strobe.
- o_rd, output, 1, RX FIFO read/pop strobe.
- o_result, output, BUS_SIZE, last received result.
- o_done, output, 1, one-cycle pulse when a result is captured.
- o_timeout, output, 1, sticky timeout flag.
- o_busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE.
  - Operand registers, o_result and the timeout counter cleared to 0.
  - o_done=0, o_timeout=0.
  - o_wr=0, o_rd=0, o_tx_data=0.
  - Reset mid-command abandons the command immediately; no partial-write recovery is attempted.
- States: IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES. State is held in a registered state variable.
- IDLE:
  - If i_start=1: latch i_op_a, i_op_b and i_op_code; clear o_timeout; go to SEND_A.
  - i_start in any other state is ignored; no queueing.
- SEND_A / SEND_B / SEND_OP:
  - o_tx_data = A, B, or {zero pad, opcode} respectively, zero-extended to BUS_SIZE.
  - o_wr = ~tx_full, combinational from the registered state and tx_full. Exactly one write per state.
  - Advance to the next state on the edge where o_wr=1. While tx_full=1, hold with o_wr=0; no timeout applies here.
  - Best case is 3 consecutive write cycles after the start cycle.
- WAIT_RES:
  - On entry, the timeout counter is 0. Each cycle with rx_empty=1, the counter increments.
  - If rx_empty=0:
    - o_rd=1 combinationally.
    - o_result <= i_rx_data on that edge.
    - o_done=1 for the following cycle.
    - Go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 while rx_empty=1:
    - o_timeout <= 1.
    - Go to IDLE.
    - o_result is unchanged; no o_done.
  - If data arrives on the same cycle the timeout would fire, the data wins: capture, no timeout.
- o_rd=0 and o_wr=0 outside the states above; o_rd and o_wr are never both high.
- Bytes already in the RX FIFO before the command is sent are consumed as the result; flushing stale data is the host's responsibility.
- Timing: o_done is registered and asserts the cycle after o_rd. A new i_start is accepted in the same cycle o_done is high (state is IDLE).

Test Plan:
- Nominal: A=0x05, B=0x03, op=0x20 (ADD), tx_full=0; RX supplies 0x08 four cycles after the opcode write.
  - Required: o_wr on 3 consecutive cycles with data 0x05, 0x03, 0x20.
  - o_rd for 1 cycle; o_result=0x08; o_done pulse; o_busy falls.
- TX back-pressure: tx_full=1 for 5 cycles during SEND_B.
  - Required: no o_wr while full; byte 0x03 written exactly once after release; total write count 3.
- Timeout: TIMEOUT_CYCLES=16, RX stays empty.
  - Required: o_timeout=1 after 16 cycles in WAIT_RES; return to IDLE; o_result keeps its prior value; no o_done.
  - A following i_start clears o_timeout.
- Start while busy: pulse i_start with A=0xFF during SEND_A.
  - Required: the in-flight command is unchanged and the TX stream still carries the original A.
- Reset mid-operation: assert i_reset while in SEND_B.
  - Required: immediately state=IDLE, o_wr=0, all outputs 0; no further writes until the next i_start.
- Boundary: data arrives on the timeout cycle (TIMEOUT_CYCLES=16, rx_empty falls at count 15) with 0xAA.
  - Required: o_result=0xAA, o_done=1, o_timeout=0.
